// File: rtl/id_imm_stage.sv
// Decode-side immediate stage: classifies RV32I opcodes, selects/composes the
// immediate and holds instructions in a 2-entry skid-buffered output stage.
module id_imm_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_instr_i,
    input  logic [DATA_WIDTH-1:0] in_pc_i,
    output logic [2:0]            ImmSrc_o,
    input  logic [DATA_WIDTH-1:0] imm_ext_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_instr_o,
    output logic [DATA_WIDTH-1:0] out_pc_o,
    output logic [DATA_WIDTH-1:0] out_imm_o,
    output logic                  out_has_imm_o,
    output logic                  out_illegal_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    localparam logic [2:0] SIGN_EXTEND_I  = 3'b000;
    localparam logic [2:0] SIGN_EXTEND_S  = 3'b001;
    localparam logic [2:0] SIGN_EXTEND_B  = 3'b010;
    localparam logic [2:0] SIGN_EXTEND_U  = 3'b011;
    localparam logic [2:0] SIGN_EXTEND_I5 = 3'b100;

    typedef enum logic [1:0] {
        CLS_EXT     = 2'd0,
        CLS_J       = 2'd1,
        CLS_NONE    = 2'd2,
        CLS_ILLEGAL = 2'd3
    } cls_e;

    cls_e                  cls_s;
    logic [DATA_WIDTH-1:0] j_imm_s;
    logic [DATA_WIDTH-1:0] in_imm_s;
    logic                  in_has_imm_s;
    logic                  in_illegal_s;
    logic                  accept_s;
    logic                  drain_s;
    logic                  m_load_s;

    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_instr_q, m_instr_d;
    logic [DATA_WIDTH-1:0] m_pc_q,    m_pc_d;
    logic [DATA_WIDTH-1:0] m_imm_q,   m_imm_d;
    logic                  m_has_q,   m_has_d;
    logic                  m_ill_q,   m_ill_d;
    logic                  k_valid_q, k_valid_d;
    logic [DATA_WIDTH-1:0] k_instr_q, k_instr_d;
    logic [DATA_WIDTH-1:0] k_pc_q,    k_pc_d;
    logic [DATA_WIDTH-1:0] k_imm_q,   k_imm_d;
    logic                  k_has_q,   k_has_d;
    logic                  k_ill_q,   k_ill_d;
    logic [CNT_WIDTH-1:0]  cnt_q,     cnt_d;

    // Opcode classification and extender select (J/none/illegal use the I code).
    always_comb begin
        cls_s    = CLS_EXT;
        ImmSrc_o = SIGN_EXTEND_I;
        case (in_instr_i[6:0])
            7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: ImmSrc_o = SIGN_EXTEND_I;
            7'b0010011: begin
                if ((in_instr_i[14:12] == 3'b001) || (in_instr_i[14:12] == 3'b101)) begin
                    ImmSrc_o = SIGN_EXTEND_I5;
                end else begin
                    ImmSrc_o = SIGN_EXTEND_I;
                end
            end
            7'b0100011:             ImmSrc_o = SIGN_EXTEND_S;
            7'b1100011:             ImmSrc_o = SIGN_EXTEND_B;
            7'b0110111, 7'b0010111: ImmSrc_o = SIGN_EXTEND_U;
            7'b1101111:             cls_s    = CLS_J;
            7'b0110011:             cls_s    = CLS_NONE;
            default:                cls_s    = CLS_ILLEGAL;
        endcase
    end

    assign j_imm_s = {{12{in_instr_i[31]}}, in_instr_i[19:12], in_instr_i[20],
                      in_instr_i[30:21], 1'b0};

    // Final immediate and flags for the incoming instruction.
    always_comb begin
        in_imm_s     = imm_ext_i;
        in_has_imm_s = 1'b1;
        in_illegal_s = 1'b0;
        case (cls_s)
            CLS_EXT:  in_imm_s = imm_ext_i;
            CLS_J:    in_imm_s = j_imm_s;
            CLS_NONE: begin
                in_imm_s     = {DATA_WIDTH{1'b0}};
                in_has_imm_s = 1'b0;
            end
            default: begin
                in_imm_s     = {DATA_WIDTH{1'b0}};
                in_has_imm_s = 1'b0;
                in_illegal_s = 1'b1;
            end
        endcase
    end

    assign in_ready_o = ~k_valid_q;
    assign accept_s   = in_valid_i & ~k_valid_q;
    assign drain_s    = m_valid_q & out_ready_i;
    assign m_load_s   = ~m_valid_q | drain_s;

    // Skid-buffer next state: K always refills M first, keeping FIFO order.
    always_comb begin
        m_valid_d = m_valid_q;
        m_instr_d = m_instr_q;
        m_pc_d    = m_pc_q;
        m_imm_d   = m_imm_q;
        m_has_d   = m_has_q;
        m_ill_d   = m_ill_q;
        k_valid_d = k_valid_q;
        k_instr_d = k_instr_q;
        k_pc_d    = k_pc_q;
        k_imm_d   = k_imm_q;
        k_has_d   = k_has_q;
        k_ill_d   = k_ill_q;
        if (flush_i) begin
            m_valid_d = 1'b0;
            k_valid_d = 1'b0;
        end else if (m_load_s) begin
            if (k_valid_q) begin
                m_valid_d = 1'b1;
                m_instr_d = k_instr_q;
                m_pc_d    = k_pc_q;
                m_imm_d   = k_imm_q;
                m_has_d   = k_has_q;
                m_ill_d   = k_ill_q;
                k_valid_d = 1'b0;
            end else if (accept_s) begin
                m_valid_d = 1'b1;
                m_instr_d = in_instr_i;
                m_pc_d    = in_pc_i;
                m_imm_d   = in_imm_s;
                m_has_d   = in_has_imm_s;
                m_ill_d   = in_illegal_s;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept_s) begin
            k_valid_d = 1'b1;
            k_instr_d = in_instr_i;
            k_pc_d    = in_pc_i;
            k_imm_d   = in_imm_s;
            k_has_d   = in_has_imm_s;
            k_ill_d   = in_illegal_s;
        end else begin
            k_valid_d = k_valid_q;
        end
    end

    // Saturating backpressure counter; flush does not touch it.
    always_comb begin
        cnt_d = cnt_q;
        if (m_valid_q && !out_ready_i && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_instr_q <= {DATA_WIDTH{1'b0}};
            m_pc_q    <= {DATA_WIDTH{1'b0}};
            m_imm_q   <= {DATA_WIDTH{1'b0}};
            m_has_q   <= 1'b0;
            m_ill_q   <= 1'b0;
            k_valid_q <= 1'b0;
            k_instr_q <= {DATA_WIDTH{1'b0}};
            k_pc_q    <= {DATA_WIDTH{1'b0}};
            k_imm_q   <= {DATA_WIDTH{1'b0}};
            k_has_q   <= 1'b0;
            k_ill_q   <= 1'b0;
            cnt_q     <= {CNT_WIDTH{1'b0}};
        end else begin
            m_valid_q <= m_valid_d;
            m_instr_q <= m_instr_d;
            m_pc_q    <= m_pc_d;
            m_imm_q   <= m_imm_d;
            m_has_q   <= m_has_d;
            m_ill_q   <= m_ill_d;
            k_valid_q <= k_valid_d;
            k_instr_q <= k_instr_d;
            k_pc_q    <= k_pc_d;
            k_imm_q   <= k_imm_d;
            k_has_q   <= k_has_d;
            k_ill_q   <= k_ill_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid_o   = m_valid_q;
    assign out_instr_o   = m_instr_q;
    assign out_pc_o      = m_pc_q;
    assign out_imm_o     = m_imm_q;
    assign out_has_imm_o = m_has_q;
    assign out_illegal_o = m_ill_q;
    assign stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_id_imm_stage.sv
// Directed bench for id_imm_stage: vector table plus backpressure, flush,
// async reset and counter saturation sequences.
module tb_id_imm_stage;

    localparam logic [2:0] C_I  = 3'b000;
    localparam logic [2:0] C_S  = 3'b001;
    localparam logic [2:0] C_B  = 3'b010;
    localparam logic [2:0] C_U  = 3'b011;
    localparam logic [2:0] C_I5 = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] in_instr = 32'd0, in_pc = 32'd0, imm_ext = 32'd0;
    logic        in_ready, out_valid, out_has, out_ill;
    logic [2:0]  imm_src;
    logic [31:0] out_instr, out_pc, out_imm;
    logic [15:0] stall_cnt;

    logic        in_valid_b = 1'b0, out_ready_b = 1'b1;
    logic        in_ready_b, out_valid_b, out_has_b, out_ill_b;
    logic [2:0]  imm_src_b;
    logic [31:0] out_instr_b, out_pc_b, out_imm_b;
    logic [3:0]  stall_cnt_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_imm_stage #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_instr_i(in_instr), .in_pc_i(in_pc), .ImmSrc_o(imm_src),
        .imm_ext_i(imm_ext), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_instr_o(out_instr), .out_pc_o(out_pc), .out_imm_o(out_imm),
        .out_has_imm_o(out_has), .out_illegal_o(out_ill), .stall_cnt_o(stall_cnt)
    );

    id_imm_stage #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush_i(1'b0),
        .in_valid_i(in_valid_b), .in_ready_o(in_ready_b),
        .in_instr_i(32'h00000013), .in_pc_i(32'h00000200), .ImmSrc_o(imm_src_b),
        .imm_ext_i(32'h00000000), .out_valid_o(out_valid_b), .out_ready_i(out_ready_b),
        .out_instr_o(out_instr_b), .out_pc_o(out_pc_b), .out_imm_o(out_imm_b),
        .out_has_imm_o(out_has_b), .out_illegal_o(out_ill_b), .stall_cnt_o(stall_cnt_b)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] ext;
        logic [2:0]  src;
        logic [31:0] imm;
        logic        has;
        logic        ill;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
    endtask

    initial begin
        vecs[0] = '{32'hFFF00093, 32'h100, 32'hFFFFFFFF, C_I,  32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[1] = '{32'h01F09093, 32'h104, 32'h0000001F, C_I5, 32'h0000001F, 1'b1, 1'b0};
        vecs[2] = '{32'hFFDFF06F, 32'h108, 32'h12345678, C_I,  32'hFFFFFFFC, 1'b1, 1'b0};
        vecs[3] = '{32'h002081B3, 32'h10C, 32'hDEAD0000, C_I,  32'h00000000, 1'b0, 1'b0};
        vecs[4] = '{32'h0000007F, 32'h110, 32'h55555555, C_I,  32'h00000000, 1'b0, 1'b1};
        vecs[5] = '{32'h00112623, 32'h114, 32'h0000000C, C_S,  32'h0000000C, 1'b1, 1'b0};
        vecs[6] = '{32'h00000463, 32'h118, 32'h00000008, C_B,  32'h00000008, 1'b1, 1'b0};
        vecs[7] = '{32'h123450B7, 32'h11C, 32'h12345000, C_U,  32'h12345000, 1'b1, 1'b0};
        vecs[8] = '{32'h4010D093, 32'h120, 32'h00000001, C_I5, 32'h00000001, 1'b1, 1'b0};
        vecs[9] = '{32'h00000073, 32'h124, 32'h00000000, C_I,  32'h00000000, 1'b1, 1'b0};

        // reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // table-driven classification, one instruction per cycle
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].instr, vecs[i].pc);
            imm_ext   = vecs[i].ext;
            out_ready = 1'b1;
            #1;
            chk($sformatf("v%0d_immsrc", i), {29'd0, imm_src}, {29'd0, vecs[i].src});
            step();
            drive(1'b0, 32'd0, 32'd0);
            chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_instr", i), out_instr, vecs[i].instr);
            chk($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
            chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
            chk($sformatf("v%0d_has", i), {31'd0, out_has}, {31'd0, vecs[i].has});
            chk($sformatf("v%0d_ill", i), {31'd0, out_ill}, {31'd0, vecs[i].ill});
        end
        step();
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_cnt", {16'd0, stall_cnt}, 32'd0);

        // backpressure: A to M, B to K, C refused while K full
        imm_ext   = 32'd0;
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h200);
        step();
        chk("bp_ready_c1", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 32'h00200093, 32'h204);
        step();
        chk("bp_ready_c2", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 32'h00300093, 32'h208);
        step();
        chk("bp_ready_c3", {31'd0, in_ready}, 32'd0);
        step();
        chk("bp_stall_cnt", {16'd0, stall_cnt}, 32'd3);
        chk("bp_hold_A", out_instr, 32'h00100093);
        chk("bp_hold_imm", out_imm, 32'd0);
        out_ready = 1'b1;
        step();
        chk("bp_rel_B", out_instr, 32'h00200093);
        chk("bp_rel_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_cnt_after", {16'd0, stall_cnt}, 32'd3);
        step();
        chk("bp_rel_C", out_instr, 32'h00300093);
        chk("bp_rel_C_pc", out_pc, 32'h208);
        drive(1'b1, 32'h00400093, 32'h20C);
        step();
        drive(1'b0, 32'd0, 32'd0);
        chk("bp_rel_D", out_instr, 32'h00400093);
        chk("bp_rel_D_valid", {31'd0, out_valid}, 32'd1);
        step();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // flush with M and K both full, input offered
        out_ready = 1'b0;
        drive(1'b1, 32'h00500093, 32'h300);
        step();
        drive(1'b1, 32'h00600093, 32'h304);
        step();
        chk("fl_k_full", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        drive(1'b1, 32'h00700093, 32'h308);
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_ready", {31'd0, in_ready}, 32'd1);
        chk("fl_cnt", {16'd0, stall_cnt}, 32'd5);
        out_ready = 1'b1;
        step();
        chk("fl_no_ghost", {31'd0, out_valid}, 32'd0);
        // flush drops an input that would otherwise be accepted into empty M
        flush = 1'b1;
        drive(1'b1, 32'h00800093, 32'h30C);
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        chk("fl_drop_in", {31'd0, out_valid}, 32'd0);
        step();
        chk("fl_drop_in2", {31'd0, out_valid}, 32'd0);

        // asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        imm_ext   = 32'h00000009;
        drive(1'b1, 32'h00900093, 32'h400);
        step();
        drive(1'b1, 32'h00A00093, 32'h404);
        step();
        drive(1'b0, 32'd0, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("ar_instr", out_instr, 32'd0);
        chk("ar_pc", out_pc, 32'd0);
        chk("ar_imm", out_imm, 32'd0);
        chk("ar_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("ar_after_valid", {31'd0, out_valid}, 32'd0);

        // saturation on the 4-bit counter instance
        out_ready_b = 1'b0;
        in_valid_b  = 1'b1;
        step();
        in_valid_b = 1'b0;
        for (int i = 0; i < 14; i++) step();
        chk("sat_cnt_14", {28'd0, stall_cnt_b}, 32'hE);
        for (int i = 0; i < 6; i++) step();
        chk("sat_cnt_20", {28'd0, stall_cnt_b}, 32'hF);
        chk("sat_hold_valid", {31'd0, out_valid_b}, 32'd1);
        chk("sat_hold_pc", out_pc_b, 32'h200);
        out_ready_b = 1'b1;
        step();
        chk("sat_cnt_kept", {28'd0, stall_cnt_b}, 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_imm_stage.md
# id_imm_stage

Decode-side immediate stage controller for the RV32I core. It accepts fetched instructions over a valid/ready handshake and classifies each opcode. It drives the immediate extender's `ImmSrc` select and composes J-type immediates, which the extender does not support. It registers instruction, PC and final immediate into a 2-entry skid-buffered output stage feeding execute, with flush support and a backpressure cycle counter.

## Interface
- `DATA_WIDTH`, 32, instruction/PC/immediate width (only 32 supported)
- `CNT_WIDTH`, 16, width of stall counter
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `flush_i` in 1: synchronous kill of all held and incoming instructions
- `in_valid_i` in 1: fetch offers an instruction
- `in_ready_o` out 1: stage can accept
- `in_instr_i` in 32: instruction word
- `in_pc_i` in 32: instruction PC
- `ImmSrc_o` out 3: extender select, combinational from `in_instr_i`, using the `SIGN_EXTEND_*` codes in def.sv
- `imm_ext_i` in 32: extender result for `in_instr_i` (combinational return path)
- `out_valid_o` out 1: execute-side entry valid
- `out_ready_i` in 1: execute accepts
- `out_instr_o`, `out_pc_o`, `out_imm_o` out 32 each: registered payload
- `out_has_imm_o` out 1: instruction uses an immediate
- `out_illegal_o` out 1: opcode not in RV32I base set
- `stall_cnt_o` out CNT_WIDTH: saturating count of cycles with `out_valid_o && !out_ready_i`

## Operation
- Classification on `in_instr_i[6:0]`, combinational:
  - 0000011 (load), 1100111 (JALR): I.
  - 0010011 (OP-IMM): I5 if funct3 is 001 or 101, else I.
  - 0100011: S.
  - 1100011: B.
  - 0110111 and 0010111: U.
  - 1101111 (JAL): J.
  - 0110011 (OP): none.
  - 0001111, 1110011: I.
  - Anything else: illegal.
- `ImmSrc_o` is the matching code. For J, none and illegal it is the I code (don't-care to the extender).
- Captured immediate:
  - J: {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0}, built internally.
  - None and illegal: 0.
  - All others: `imm_ext_i`.
- `has_imm` = 1 for all classes except none and illegal. `illegal` is 1 only for the illegal class.
- Storage: main output register (M) plus one skid register (K), each holding payload (instr, pc, imm, has_imm, illegal) and a valid bit.
- Handshake terms:
  - accept = `in_valid_i && in_ready_o`.
  - drain = `out_valid_o && out_ready_i`.
  - `in_ready_o` = !K.valid (registered-derived, no combinational path from `out_ready_i`).
- M loads when !M.valid or drain:
  - from K if K.valid; K clears.
  - else from the input if accept.
  - else M.valid goes to 0.
- Input goes to K when accept and M cannot load it: M.valid && !drain.
- Order is strictly FIFO. K is older than any new input.
- `out_*` reflect M; `out_valid_o` = M.valid.
- `flush_i`: next cycle M.valid = K.valid = 0; any same-cycle input is dropped; the counter is unaffected. Flush has priority over accept and drain.
- Stall counter: increments when `out_valid_o && !out_ready_i` and saturates at all-ones. It clears only on reset.
- Reset state: M.valid = K.valid = 0 and all payload = 0. So `out_valid_o` = 0, `out_*` = 0, `stall_cnt_o` = 0, `in_ready_o` = 1.
- Reset asserted mid-operation discards held entries immediately (asynchronously).

## Timing
- Latency: instruction accepted at edge N appears on `out_*` after edge N (visible in cycle N+1) when M is free or draining.
- Throughput: 1 instruction/cycle while `out_ready_i` = 1.
- Stall: with M full and not draining, one more input is accepted into K. `in_ready_o` drops the following cycle and stays low until K moves to M.
- Release: first drain after a stall moves K to M. `in_ready_o` returns high one cycle later. There are no bubbles and no duplicates.
- Payload of M is stable while `out_valid_o && !out_ready_i`.
- `ImmSrc_o` is purely combinational from `in_instr_i`. `imm_ext_i` must settle within the same cycle.

## Test plan
- Reset then ADDI 0xFFF00093 at pc 0x100, `out_ready_i` = 1 → next cycle: `out_valid_o` = 1, `out_imm_o` = 0xFFFFFFFF, `out_has_imm_o` = 1, `out_pc_o` = 0x100, `ImmSrc_o` = I code during input.
- SLLI 0x01F09093 → `ImmSrc_o` = I5 code, `out_imm_o` = 0x0000001F. JAL 0xFFDFF06F → `out_imm_o` = 0xFFFFFFFC. ADD 0x002081B3 → `out_imm_o` = 0, `out_has_imm_o` = 0. Word 0x0000007F → `out_illegal_o` = 1.
- Backpressure: stream 4 instructions with `out_ready_i` = 0 for 3 cycles → exactly 2 accepted, `in_ready_o` = 0 from the 3rd cycle, `stall_cnt_o` = 3. On release the outputs appear in order with no loss or duplication.
- Flush while M and K are both valid, with `in_valid_i` = 1 → next cycle `out_valid_o` = 0, `in_ready_o` = 1, and the flushed input never appears.
- Assert `rst_n` = 0 mid-stall → `out_valid_o`, `stall_cnt_o` and `out_*` go to 0 immediately and `in_ready_o` = 1.
- Counter saturation with CNT_WIDTH = 4: hold the stall 20 cycles → `stall_cnt_o` = 0xF.
